// File: rtl/serial_ppp_rx.sv
// -----------------------------------------------------------------------------
// serial_ppp_rx
// Purpose : PPP (HDLC-like) byte-stream deframer. Strips FLAG (0x7E)
//           delimiters, undoes ESC (0x7D) byte stuffing, enforces a maximum
//           frame length and reports each frame close as good or bad.
// Optional: define SERIAL_PPP_RX_FCS_EN to add PPP FCS-16 checking. Two
//           bytes are held back so the trailing FCS is never output.
// Ports   :
//   mclk        in   master clock
//   reset       in   asynchronous active-high reset
//   rx_data     in   [7:0] received byte
//   rx_strobe   in   rx_data valid (one cycle per byte)
//   out_data    out  [7:0] unescaped payload byte
//   out_strobe  out  out_data valid (one cycle)
//   out_first   out  first payload byte of a frame (with out_strobe)
//   pkt_end     out  frame close pulse
//   pkt_error   out  with pkt_end: 1 = discard frame
// -----------------------------------------------------------------------------
module serial_ppp_rx #(
    parameter int unsigned MAX_LEN = 255
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] out_data,
    output logic       out_strobe,
    output logic       out_first,
    output logic       pkt_end,
    output logic       pkt_error
);

    localparam int unsigned LEN_W = 9;
    localparam logic [LEN_W-1:0] LEN_MAX_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = '1;
    localparam logic [7:0] FLAG_B = 8'h7E;
    localparam logic [7:0] ESC_B  = 8'h7D;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_DATA,
        ST_ESC
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic             r_err, w_err_nxt;
    logic             r_first, w_first_nxt;
    logic [7:0]       r_out_data, w_out_data_nxt;
    logic             r_out_strobe, w_out_strobe_nxt;
    logic             r_out_first, w_out_first_nxt;
    logic             r_pkt_end, w_pkt_end_nxt;
    logic             r_pkt_error, w_pkt_error_nxt;

    logic             w_open;
    logic             w_is_data;
    logic [7:0]       w_data_byte;
    logic             w_close_err;

`ifdef SERIAL_PPP_RX_FCS_EN
    logic [15:0] r_crc, w_crc_nxt;
    logic [7:0]  r_hold0, w_hold0_nxt;
    logic [7:0]  r_hold1, w_hold1_nxt;
    logic [1:0]  r_hold_cnt, w_hold_cnt_nxt;

    // Reflected CRC-16 (poly 0x8408) update over one byte.
    function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // Good residue after the FCS has been run through the CRC.
    assign w_close_err = r_err | (r_len < 9'd3) | (r_crc != 16'hF0B8);
`else
    assign w_close_err = r_err;
`endif

    // State and output registers.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HUNT;
            r_len        <= '0;
            r_err        <= 1'b0;
            r_first      <= 1'b1;
            r_out_data   <= '0;
            r_out_strobe <= 1'b0;
            r_out_first  <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_pkt_error  <= 1'b0;
`ifdef SERIAL_PPP_RX_FCS_EN
            r_crc        <= 16'hFFFF;
            r_hold0      <= '0;
            r_hold1      <= '0;
            r_hold_cnt   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_err        <= w_err_nxt;
            r_first      <= w_first_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_strobe <= w_out_strobe_nxt;
            r_out_first  <= w_out_first_nxt;
            r_pkt_end    <= w_pkt_end_nxt;
            r_pkt_error  <= w_pkt_error_nxt;
`ifdef SERIAL_PPP_RX_FCS_EN
            r_crc        <= w_crc_nxt;
            r_hold0      <= w_hold0_nxt;
            r_hold1      <= w_hold1_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_len_nxt        = r_len;
        w_err_nxt        = r_err;
        w_first_nxt      = r_first;
        w_out_data_nxt   = r_out_data;
        w_out_strobe_nxt = 1'b0;
        w_out_first_nxt  = 1'b0;
        w_pkt_end_nxt    = 1'b0;
        w_pkt_error_nxt  = 1'b0;
        w_open           = 1'b0;
        w_is_data        = 1'b0;
        w_data_byte      = rx_data;
`ifdef SERIAL_PPP_RX_FCS_EN
        w_crc_nxt        = r_crc;
        w_hold0_nxt      = r_hold0;
        w_hold1_nxt      = r_hold1;
        w_hold_cnt_nxt   = r_hold_cnt;
`endif

        if (rx_strobe) begin
            case (r_state)
                ST_HUNT: begin
                    if (rx_data == FLAG_B) begin
                        w_open      = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_data == FLAG_B) begin
                        // Empty frames (idle / back-to-back flags) close silently.
                        if (r_len != '0) begin
                            w_pkt_end_nxt   = 1'b1;
                            w_pkt_error_nxt = w_close_err;
                        end
                        w_open = 1'b1;
                    end else if (rx_data == ESC_B) begin
                        w_state_nxt = ST_ESC;
                    end else begin
                        w_is_data = 1'b1;
                    end
                end
                ST_ESC: begin
                    w_state_nxt = ST_DATA;
                    if (rx_data == FLAG_B) begin
                        // ESC followed by FLAG is an abort sequence.
                        if ((r_len != '0) || r_err) begin
                            w_pkt_end_nxt   = 1'b1;
                            w_pkt_error_nxt = 1'b1;
                        end
                        w_open = 1'b1;
                    end else begin
                        w_is_data   = 1'b1;
                        w_data_byte = rx_data ^ 8'h20;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end

        // Frame open: every flag starts a fresh frame.
        if (w_open) begin
            w_len_nxt   = '0;
            w_err_nxt   = 1'b0;
            w_first_nxt = 1'b1;
`ifdef SERIAL_PPP_RX_FCS_EN
            w_crc_nxt      = 16'hFFFF;
            w_hold_cnt_nxt = '0;
`endif
        end

        // Data byte: count it, drop once the frame exceeds MAX_LEN.
        if (w_is_data) begin
            w_len_nxt = (r_len == LEN_SAT) ? r_len : (r_len + 9'd1);
            if (r_len >= LEN_MAX_V) begin
                w_err_nxt = 1'b1;
            end else begin
`ifdef SERIAL_PPP_RX_FCS_EN
                w_crc_nxt = crc_upd(r_crc, w_data_byte);
                case (r_hold_cnt)
                    2'd0: begin
                        w_hold0_nxt    = w_data_byte;
                        w_hold_cnt_nxt = 2'd1;
                    end
                    2'd1: begin
                        w_hold1_nxt    = w_data_byte;
                        w_hold_cnt_nxt = 2'd2;
                    end
                    default: begin
                        // Third byte pushes the oldest held byte out.
                        w_out_strobe_nxt = 1'b1;
                        w_out_data_nxt   = r_hold0;
                        w_out_first_nxt  = r_first;
                        w_first_nxt      = 1'b0;
                        w_hold0_nxt      = r_hold1;
                        w_hold1_nxt      = w_data_byte;
                    end
                endcase
`else
                w_out_strobe_nxt = 1'b1;
                w_out_data_nxt   = w_data_byte;
                w_out_first_nxt  = r_first;
                w_first_nxt      = 1'b0;
`endif
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_strobe = r_out_strobe;
    assign out_first  = r_out_first;
    assign pkt_end    = r_pkt_end;
    assign pkt_error  = r_pkt_error;

endmodule

// File: tb/tb_serial_ppp_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_ppp_rx
// Purpose : self-checking bench for serial_ppp_rx. Frames are built at the
//           payload level, encoded into a byte stream, and the expected output
//           events are derived per frame from its byte list and positions.
// Honors SERIAL_PPP_RX_FCS_EN (holdback of 2, CRC residue check).
// -----------------------------------------------------------------------------
module tb_serial_ppp_rx;

`ifdef SERIAL_PPP_RX_FCS_EN
    localparam bit FCS_ON = 1'b1;
    localparam int HB     = 2;
    localparam int TB_MAX = 16;
`else
    localparam bit FCS_ON = 1'b0;
    localparam int HB     = 0;
    localparam int TB_MAX = 4;
`endif

    logic       mclk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] out_data;
    logic       out_strobe;
    logic       out_first;
    logic       pkt_end;
    logic       pkt_error;

    serial_ppp_rx #(.MAX_LEN(TB_MAX)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_strobe  (rx_strobe),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .out_first  (out_first),
        .pkt_end    (pkt_end),
        .pkt_error  (pkt_error)
    );

    initial mclk = 1'b0;
    always #10 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;

    // Stream bytes and the expected event after each (0 none, 1 byte out, 2 end).
    logic [7:0] s_byte[$];
    int         e_kind[$];
    logic [7:0] e_data[$];
    bit         e_first[$];
    bit         e_err[$];
    int         run_ptr = 0;

    // Currently open frame in the model.
    bit         f_open = 1'b0;
    logic [7:0] f_data[$];
    int         f_pos[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (q[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ q[k][i];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic put_raw(input logic [7:0] b, output int idx);
        s_byte.push_back(b);
        e_kind.push_back(0);
        e_data.push_back(8'h00);
        e_first.push_back(1'b0);
        e_err.push_back(1'b0);
        idx = s_byte.size() - 1;
    endtask

    // Assign the expected events of the open frame, given how it ends.
    task automatic finish_frame(input int end_idx, input bit abort, input bit cut);
        int n;
        int a;
        int p;
        n = f_data.size();
        a = (n > TB_MAX) ? TB_MAX : n;
        for (int i = 0; i + HB < a; i++) begin
            p          = f_pos[i + HB];
            e_kind[p]  = 1;
            e_data[p]  = f_data[i];
            e_first[p] = (i == 0);
        end
        if (!cut && n > 0) begin
            e_kind[end_idx] = 2;
            if (abort)
                e_err[end_idx] = 1'b1;
            else
                e_err[end_idx] = (n > TB_MAX) ||
                                 (FCS_ON && ((n < 3) || (crc_of(f_data) != 16'hF0B8)));
        end
        f_data.delete();
        f_pos.delete();
    endtask

    task automatic send_flag();
        int idx;
        put_raw(8'h7E, idx);
        if (f_open) finish_frame(idx, 1'b0, 1'b0);
        f_open = 1'b1;
    endtask

    task automatic send_abort();
        int idx;
        put_raw(8'h7D, idx);
        put_raw(8'h7E, idx);
        if (f_open) finish_frame(idx, 1'b1, 1'b0);
        f_open = 1'b1;
    endtask

    task automatic send_data(input logic [7:0] b, input bit force_esc);
        int idx;
        if (b == 8'h7E || b == 8'h7D || (force_esc && b != 8'h5E)) begin
            put_raw(8'h7D, idx);
            put_raw(b ^ 8'h20, idx);
        end else begin
            put_raw(b, idx);
        end
        if (f_open) begin
            f_data.push_back(b);
            f_pos.push_back(idx);
        end
    endtask

    // One clock: optionally strobe a byte, then compare the following cycle.
    task automatic step(input bit stb, input logic [7:0] b, input int k,
                        input logic [7:0] d, input bit first, input bit err);
        logic [11:0] got;
        logic [11:0] exp;
        rx_strobe = stb;
        rx_data   = b;
        @(posedge mclk);
        @(negedge mclk);
        rx_strobe = 1'b0;
        got = {out_strobe, out_first, (out_strobe ? out_data : 8'h00),
               pkt_end, (pkt_end ? pkt_error : 1'b0)};
        exp = {(k == 1), (k == 1) && first, ((k == 1) ? d : 8'h00),
               (k == 2), (k == 2) && err};
        chk(stb ? "byte_evt" : "idle_evt", 32'(got), 32'(exp));
    endtask

    task automatic run_stream();
        int gap;
        while (run_ptr < s_byte.size()) begin
            gap = $urandom_range(0, 2);
            repeat (gap) step(1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0);
            step(1'b1, s_byte[run_ptr], e_kind[run_ptr], e_data[run_ptr],
                 e_first[run_ptr], e_err[run_ptr]);
            run_ptr++;
        end
        repeat (2) step(1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge mclk);
        chk("reset_out", 32'({out_data, out_strobe, out_first, pkt_end, pkt_error}), 32'h0);
        @(negedge mclk);
        reset  = 1'b0;
        f_open = 1'b0;
        f_data.delete();
        f_pos.delete();
    endtask

    task automatic cut_and_reset();
        finish_frame(-1, 1'b0, 1'b1);
        run_stream();
        do_reset();
    endtask

    initial begin
        logic [7:0] pay[$];
        logic [15:0] fcs;
        int          p;
        int          r;

        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_strobe = 1'b0;
        repeat (2) @(negedge mclk);
        do_reset();

        // 7E 01 02 7E
        send_flag(); send_data(8'h01, 0); send_data(8'h02, 0); send_flag();
        // 7E 7D 5E 7D 5D 7E
        send_data(8'h7E, 0); send_data(8'h7D, 0); send_flag();
        // idle flags then an abort on an empty frame
        send_flag(); send_flag(); send_abort();
        run_stream();

        // Reset mid-frame, then garbage in HUNT
        send_data(8'h11, 0); send_data(8'h22, 0); send_data(8'h33, 0);
        cut_and_reset();
        send_data(8'h55, 0); send_flag(); send_data(8'hAA, 0); send_flag();
        run_stream();

        // Overflow followed by a short clean frame
        for (int i = 1; i <= TB_MAX + 2; i++) send_data(8'(i), 0);
        send_flag(); send_data(8'h09, 0); send_flag();
        run_stream();

        // "123456789" with good and bad FCS, then a two-byte frame
        for (int i = 0; i < 9; i++) send_data(8'h31 + 8'(i), 0);
        send_data(8'h6E, 0); send_data(8'h90, 0); send_flag();
        for (int i = 0; i < 9; i++) send_data(8'h31 + 8'(i), 0);
        send_data(8'h6E, 0); send_data(8'h91, 0); send_flag();
        send_data(8'h01, 0); send_data(8'h02, 0); send_flag();
        run_stream();

        // Randomized frames
        for (int fr = 0; fr < 150; fr++) begin
            pay.delete();
            p = FCS_ON ? $urandom_range(0, TB_MAX) : $urandom_range(0, TB_MAX + 2);
            for (int i = 0; i < p; i++) begin
                case ($urandom_range(0, 7))
                    0: pay.push_back(8'h7E);
                    1: pay.push_back(8'h7D);
                    2: pay.push_back(8'h5E);
                    default: pay.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            if (FCS_ON && $urandom_range(0, 3) != 0) begin
                fcs = ~crc_of(pay);
                if ($urandom_range(0, 2) == 0) fcs = fcs ^ (16'h1 << $urandom_range(0, 15));
                pay.push_back(fcs[7:0]);
                pay.push_back(fcs[15:8]);
            end
            foreach (pay[i]) send_data(pay[i], $urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_abort();
            end else if (r == 1) begin
                cut_and_reset();
                repeat ($urandom_range(0, 2)) send_data(8'($urandom_range(0, 255)), 0);
                send_flag();
            end else begin
                send_flag();
            end
            if ($urandom_range(0, 3) == 0) send_flag();
            run_stream();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_ppp_rx.md
SERIAL_PPP_RX -- requirements
Module: serial_ppp_rx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 255, giving the maximum unescaped bytes per frame (FCS included); legal range 1..510.
REQ-002 SHALL have port mclk, input, 1, master clock (50 MHz).
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rx_data, input, 8, received byte from the UART receiver.
REQ-005 SHALL have port rx_strobe, input, 1, one-cycle pulse while rx_data is valid.
REQ-006 SHALL have port out_data, output, 8, unescaped payload byte.
REQ-007 SHALL have port out_strobe, output, 1, one-cycle pulse while out_data is valid.
REQ-008 SHALL have port out_first, output, 1, high with out_strobe on the first payload byte of a frame.
REQ-009 SHALL have port pkt_end, output, 1, one-cycle pulse at frame close.
REQ-010 SHALL have port pkt_error, output, 1, valid with pkt_end; 1 means discard the frame.

Function
REQ-011 SHALL implement states HUNT, DATA and ESC; constants FLAG=0x7E, ESC=0x7D.
REQ-012 SHALL act only on cycles with rx_strobe=1 and SHALL accept rx_strobe on consecutive cycles.
REQ-013 In HUNT: FLAG -> DATA with len=0 and err=0; all other bytes are dropped.
REQ-014 In DATA, FLAG with len=0 SHALL be ignored (idle or back-to-back flags); no pkt_end.
REQ-015 In DATA, FLAG with len>0 SHALL pulse pkt_end, with pkt_error=err, one cycle after rx_strobe; then stay in DATA with len=0 and err=0 (the closing flag also opens the next frame).
REQ-016 In DATA, ESC -> ESC state; no output.
REQ-017 In ESC, FLAG SHALL abort: pkt_end with pkt_error=1 if len>0 or err=1 (else no pulse); then DATA with len=0 and err=0.
REQ-018 In ESC, any other byte b SHALL be processed as data byte b XOR 0x20; then DATA.
REQ-019 Data byte in DATA or ESC: len increments, saturating at 511; if len would exceed MAX_LEN, set err and drop the byte and all later bytes until the next FLAG.
REQ-020 out_strobe SHALL pulse exactly one cycle after the rx_strobe that releases the byte.
REQ-021 out_first SHALL be 1 only for the first released byte after a frame open.
REQ-022 out_strobe and pkt_end SHALL never be high in the same cycle.
REQ-023 Released bytes of an errored frame SHALL still be output; pkt_error marks the frame bad.

Reset
REQ-024 reset SHALL force HUNT, len=0, err=0, holdback empty, CRC=0xFFFF, and out_data, out_strobe, out_first, pkt_end and pkt_error all 0.
REQ-025 reset mid-frame SHALL discard the partial frame without a pkt_end; the first byte after reset is processed normally in HUNT.

Configuration
REQ-026 Macro SERIAL_PPP_RX_FCS_EN SHALL enable PPP FCS-16 checking.
REQ-027 With the macro defined: a 2-byte holdback is used, and a data byte is released only when a third byte arrives.
  - The 2 held bytes at FLAG are the FCS and are never output.
  - The CRC uses reflected polynomial 0x8408 with init 0xFFFF, updated over every accepted data byte including the FCS.
  - At a FLAG, pkt_error=1 if err, or len<3, or CRC≠0xF0B8.
  - The CRC is reset to 0xFFFF at every frame open.
REQ-028 Without the macro: no holdback and no CRC logic; each data byte is released immediately; pkt_error=err.

Verification
REQ-029 FCS off: 7E 01 02 7E -> out 01(first), 02, then pkt_end with pkt_error=0.
REQ-030 FCS off: 7E 7D 5E 7D 5D 7E -> out 7E(first), 7D, then pkt_end with pkt_error=0.
REQ-031 Abort and HUNT handling:
  - 7E 7E 7E 7D 7E -> no out_strobe and no pkt_end.
  - Reset, then 55 7E AA 7E -> 55 ignored, out AA, pkt_end with pkt_error=0.
REQ-032 Overflow (MAX_LEN=4, FCS off): 7E 01 02 03 04 05 06 7E -> out 01..04, pkt_end with pkt_error=1; a following 09 7E -> out 09, pkt_end with pkt_error=0.
REQ-033 FCS on: 7E "123456789" 6E 90 7E -> out 31..39, pkt_end with pkt_error=0; repeating with last byte 91 -> pkt_error=1.
REQ-034 FCS on: 7E 01 02 7E -> no out_strobe, pkt_end with pkt_error=1 (len<3).
